// File: rtl/rv32i_types.sv
// Shared RV32I execute-stage types.
// Holds the ALU and multiply/divide operation encodings plus small decode helpers.
package rv32i_types;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  // Encoding equals the RV32M funct3 field.
  typedef enum logic [2:0] {
    md_mul    = 3'b000,
    md_mulh   = 3'b001,
    md_mulhsu = 3'b010,
    md_mulhu  = 3'b011,
    md_div    = 3'b100,
    md_divu   = 3'b101,
    md_rem    = 3'b110,
    md_remu   = 3'b111
  } md_ops;

  // rs1 is treated as signed for these ops.
  function automatic logic md_signed_a(input md_ops op);
    return (op == md_mul) || (op == md_mulh) || (op == md_mulhsu) ||
           (op == md_div) || (op == md_rem);
  endfunction

  // rs2 is treated as signed for these ops.
  function automatic logic md_signed_b(input md_ops op);
    return (op == md_mul) || (op == md_mulh) || (op == md_div) || (op == md_rem);
  endfunction

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement: y = neg ? -x : x.
// Ports: x (W-bit input), neg (negate enable), y (W-bit result, combinational).
module md_negate #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiplier and
// restoring divider sharing one {hi,lo} datapath, with sign fixup stage.
// Ports: clk, rst (async active-high), start, mdop, a, b in;
//        busy (state != idle), done (one-cycle pulse), f (result register) out.
module md_unit
  import rv32i_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_ops           mdop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] f
);

  localparam int unsigned W     = XLEN;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    s_idle  = 2'b00,
    s_calc  = 2'b01,
    s_fixup = 2'b10,
    s_done  = 2'b11
  } md_state_t;

  md_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  md_ops            op, op_n;
  logic             sgn, sgn_n;     // product / quotient sign
  logic             rsgn, rsgn_n;   // remainder sign
  logic [W-1:0]     hi, hi_n;       // product high word / remainder
  logic [W-1:0]     lo, lo_n;       // product low word / quotient
  logic [W-1:0]     opb, opb_n;     // multiplicand / divisor magnitude
  logic [W-1:0]     f_n;

  // Operand magnitudes
  logic         sa, sb;
  logic [W-1:0] abs_a, abs_b;

  assign sa = a[W-1] & md_signed_a(mdop);
  assign sb = b[W-1] & md_signed_b(mdop);

  md_negate #(.W(W)) u_neg_a (.x(a), .neg(sa), .y(abs_a));
  md_negate #(.W(W)) u_neg_b (.x(b), .neg(sb), .y(abs_b));

  // Sign correction: low word of the 64-bit negation doubles as the quotient negation.
  logic [2*W-1:0] fix_p;
  logic [W-1:0]   fix_r;

  md_negate #(.W(2*W)) u_neg_p (.x({hi, lo}), .neg(sgn),  .y(fix_p));
  md_negate #(.W(W))   u_neg_r (.x(hi),       .neg(rsgn), .y(fix_r));

  // Special cases resolved at accept time
  logic is_div, div_zero, div_ovf;

  assign is_div   = mdop[2];
  assign div_zero = is_div && (b == '0);
  assign div_ovf  = ((mdop == md_div) || (mdop == md_rem)) &&
                    (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);

  // One multiply step: conditional add with carry, then shift right.
  logic [W:0] madd;
  assign madd = {1'b0, hi} + (lo[0] ? {1'b0, opb} : (W+1)'(0));

  // One restoring divide step: shift left, trial subtract.
  logic [W:0] dsh, dsub;
  logic       dge;
  assign dsh  = {hi, lo[W-1]};
  assign dge  = (dsh >= {1'b0, opb});
  assign dsub = dsh - {1'b0, opb};

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= s_idle;
      cnt   <= '0;
      op    <= md_mul;
      sgn   <= 1'b0;
      rsgn  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      opb   <= '0;
      f     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op    <= op_n;
      sgn   <= sgn_n;
      rsgn  <= rsgn_n;
      hi    <= hi_n;
      lo    <= lo_n;
      opb   <= opb_n;
      f     <= f_n;
      busy  <= (state_n != s_idle);
      done  <= (state_n == s_done);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op;
    sgn_n   = sgn;
    rsgn_n  = rsgn;
    hi_n    = hi;
    lo_n    = lo;
    opb_n   = opb;
    f_n     = f;

    case (state)
      s_idle: begin
        if (start) begin
          op_n   = mdop;
          sgn_n  = sa ^ sb;
          rsgn_n = sa;
          hi_n   = '0;
          lo_n   = is_div ? abs_a : abs_b;
          opb_n  = is_div ? abs_b : abs_a;
          cnt_n  = '0;
          if (div_zero) begin
            f_n     = mdop[1] ? a : '1;
            state_n = s_done;
          end else if (div_ovf) begin
            f_n     = mdop[1] ? '0 : {1'b1, {(W-1){1'b0}}};
            state_n = s_done;
          end else begin
            state_n = s_calc;
          end
        end
      end

      s_calc: begin
        if (op[2]) begin
          hi_n = dge ? dsub[W-1:0] : dsh[W-1:0];
          lo_n = {lo[W-2:0], dge};
        end else begin
          hi_n = madd[W:1];
          lo_n = {madd[0], lo[W-1:1]};
        end
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(W-1)) begin
          state_n = s_fixup;
        end
      end

      s_fixup: begin
        case (op)
          md_mul:                        f_n = fix_p[W-1:0];
          md_mulh, md_mulhsu, md_mulhu:  f_n = fix_p[2*W-1:W];
          md_div, md_divu:               f_n = fix_p[W-1:0];
          default:                       f_n = fix_r;
        endcase
        state_n = s_done;
      end

      s_done: begin
        state_n = s_idle;
      end

      default: begin
        state_n = s_idle;
      end
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed ops, special cases, ignored
// starts, back-to-back accept and asynchronous reset abort.
module tb_md_unit;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  md_ops       mdop;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] f;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  md_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mdop  (mdop),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .f     (f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; drives start for one cycle and waits for done.
  task automatic do_op(input string tag, input md_ops op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] ef, input int elat);
    int cyc;
    start = 1'b1; mdop = op; a = av; b = bv;
    sb.push_back(ef);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 1;
    chk({tag, ".busy1"}, 32'(busy), 32'd1);
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".lat"}, 32'(cyc), 32'(elat));
    exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
    chk({tag, ".f"}, f, exp_v);
    @(negedge clk);
    chk({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    logic [31:0] hold_f;
    rst = 1'b1; start = 1'b0; mdop = md_mul; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.f", f, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Multiply variants
    do_op("mul",    md_mul,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    do_op("mulh",   md_mulh,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34);
    do_op("mulhu",  md_mulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    do_op("mulhsu", md_mulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    do_op("mulhbig",md_mulh,   32'h80000000, 32'h80000000, 32'h40000000, 34);

    // Divide variants
    do_op("div",    md_div,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    do_op("rem",    md_rem,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    do_op("divu",   md_divu,   32'd100,      32'd7,        32'd14,       34);
    do_op("remu",   md_remu,   32'd100,      32'd7,        32'd2,        34);
    do_op("divneg", md_div,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    do_op("remneg", md_rem,    32'd7,        32'hFFFFFFFE, 32'd1,        34);
    do_op("divu1",  md_divu,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34);

    // Special-case shortcuts
    do_op("div0",   md_div,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    do_op("remu0",  md_remu,   32'd5,        32'd0,        32'd5,        1);
    do_op("divovf", md_div,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("removf", md_rem,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Starts during a running op are ignored; f holds until done
    hold_f = 32'd0;
    start = 1'b1; mdop = md_mul; a = 32'h12345678; b = 32'h10;
    sb.push_back(32'h23456780);
    @(negedge clk);
    ndone = 0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      if (cyc == 5 || cyc == 20 || cyc == 34) begin
        start = 1'b1; mdop = md_div; a = 32'd5; b = 32'd0;
      end else begin
        start = 1'b0;
      end
      if (done) ndone++;
      if (cyc == 20) chk("ign.f_hold", f, hold_f);
      if (cyc == 33) chk("ign.f_hold33", f, hold_f);
      if (cyc == 34) begin
        chk("ign.done34", 32'(done), 32'd1);
        exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
        chk("ign.f", f, exp_v);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign.idle35", {30'd0, busy, done}, 32'd0);
    chk("ign.ndone", 32'(ndone), 32'd1);

    // Back-to-back accept in cycle 35
    do_op("b2b", md_mulhu, 32'h80000000, 32'd4, 32'd2, 34);

    // Asynchronous reset mid-CALC aborts with no done pulse
    start = 1'b1; mdop = md_mul; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("rst.busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.f", f, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst.nodone", 32'(ndone), 32'd0);
    chk("rst.f_idle", f, 32'd0);
    do_op("post_rst", md_mul, 32'd3, 32'd4, 32'd12, 34);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
